decode_scan_n: RTL and testbench

DECODE_SCAN_N -- requirements
Module: decode_scan_n

---
 rtl/decode_pkg.sv | 16 +
 rtl/decode_scan_n_onehot_dec.sv | 14 +
 rtl/decode_scan_n.sv | 108 ++++++++++
 tb/tb_decode_scan_n.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - mode encodings and state enumeration for the scanning decoder
package decode_pkg;

  localparam logic [1:0] MODE_DIRECT  = 2'b00;
  localparam logic [1:0] MODE_SCAN_UP = 2'b01;
  localparam logic [1:0] MODE_SCAN_DN = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/decode_scan_n_onehot_dec.sv
// rtl/decode_scan_n_onehot_dec.sv - combinational N-to-2**N one-hot decoder
module onehot_dec #(
  parameter int N = 2
) (
  input  logic [N-1:0]      addr,
  output logic [2**N-1:0]   y
);

  always_comb begin
    y       = '0;
    y[addr] = 1'b1;
  end

endmodule

// File: rtl/decode_scan_n.sv
// rtl/decode_scan_n.sv - registered one-hot decoder with direct, scan and hold modes
module decode_scan_n
  import decode_pkg::*;
#(
  parameter int N           = 2,
  parameter int DW          = 4,
  parameter int IDLE_ONEHOT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              En,
  input  logic [1:0]        Mode,
  input  logic [N-1:0]      I,
  input  logic              Start,
  input  logic [DW-1:0]     Dwell,
  output logic [2**N-1:0]   Y,
  output logic [N-1:0]      Idx,
  output logic              Vld,
  output logic              Wrap,
  output logic              Busy
);

  localparam int OW = 2**N;
  localparam logic [OW-1:0] Y_IDLE = (IDLE_ONEHOT != 0) ? OW'(1) : OW'(0);

  state_t         state;
  logic [DW-1:0]  cnt;
  logic [DW-1:0]  dwell_q;
  logic           scan_mode;
  logic           load_i;
  logic [N-1:0]   step_idx;
  logic           step_wrap;
  logic [N-1:0]   dec_addr;
  logic [OW-1:0]  dec_y;

  // The single decoder sees whichever index will be registered next.
  always_comb begin
    scan_mode = (Mode == MODE_SCAN_UP) || (Mode == MODE_SCAN_DN);
    load_i    = (Mode == MODE_DIRECT) || (scan_mode && Start);
    step_idx  = (Mode == MODE_SCAN_UP) ? Idx + N'(1) : Idx - N'(1);
    step_wrap = (Mode == MODE_SCAN_UP) ? (Idx == {N{1'b1}}) : (Idx == '0);
    dec_addr  = load_i ? I : step_idx;
  end

  onehot_dec #(.N(N)) u_dec (
    .addr (dec_addr),
    .y    (dec_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      Y       <= Y_IDLE;
      Idx     <= '0;
      Vld     <= 1'b0;
      Wrap    <= 1'b0;
      Busy    <= 1'b0;
      cnt     <= '0;
      dwell_q <= '0;
    end else begin
      Wrap <= 1'b0;
      if (!En) begin
        state <= ST_IDLE;
        Y     <= Y_IDLE;
        Vld   <= 1'b0;
        Busy  <= 1'b0;
        cnt   <= '0;
      end else if (Mode == MODE_DIRECT) begin
        state <= ST_DIRECT;
        Y     <= dec_y;
        Idx   <= I;
        Vld   <= 1'b1;
        Busy  <= 1'b0;
        cnt   <= '0;
      end else if (scan_mode && Start) begin
        state   <= ST_SCAN;
        Y       <= dec_y;
        Idx     <= I;
        Vld     <= 1'b1;
        Busy    <= 1'b1;
        cnt     <= '0;
        dwell_q <= Dwell;
      end else begin
        case (state)
          ST_SCAN: begin
            if (Mode == MODE_HOLD) begin
              state <= ST_HOLD;
            end else if (cnt == dwell_q) begin
              // Step boundary: the new dwell length is captured for the step being entered.
              cnt     <= '0;
              dwell_q <= Dwell;
              Idx     <= step_idx;
              Y       <= dec_y;
              Wrap    <= step_wrap;
            end else begin
              cnt <= cnt + DW'(1);
            end
          end
          ST_HOLD: begin
            if (scan_mode) state <= ST_SCAN;
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode_scan_n.sv
// tb/tb_decode_scan_n.sv - directed self-checking bench for decode_scan_n
module tb_decode_scan_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, start;
  logic [1:0] mode;
  logic [1:0] i_addr;
  logic [3:0] dwell;
  logic [3:0] y;
  logic [1:0] idx;
  logic       vld, wrap, busy;

  logic       en3, start3;
  logic [1:0] mode3;
  logic [2:0] i3;
  logic [3:0] dwell3;
  logic [7:0] y3;
  logic [2:0] idx3;
  logic       vld3, wrap3, busy3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_scan_n #(.N(2), .DW(4), .IDLE_ONEHOT(0)) dut (
    .clk(clk), .rst_n(rst_n), .En(en), .Mode(mode), .I(i_addr), .Start(start),
    .Dwell(dwell), .Y(y), .Idx(idx), .Vld(vld), .Wrap(wrap), .Busy(busy)
  );

  decode_scan_n #(.N(3), .DW(4), .IDLE_ONEHOT(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .En(en3), .Mode(mode3), .I(i3), .Start(start3),
    .Dwell(dwell3), .Y(y3), .Idx(idx3), .Vld(vld3), .Wrap(wrap3), .Busy(busy3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL reset_y got %b want 0000", y); end
    checks++; if (idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", idx); end
    checks++; if ({vld, wrap, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {vld, wrap, busy}); end
    checks++; if (y3 !== 8'b0000_0001) begin errors++; $display("FAIL reset_y3 got %b want 00000001", y3); end
    checks++; if ({vld3, busy3} !== 2'b00) begin errors++; $display("FAIL reset_flags3 got %b want 00", {vld3, busy3}); end
    rst_n = 1'b1;
  endtask

  task automatic test_direct;
    logic [3:0] ey [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    en = 1'b1; mode = 2'b00; dwell = 4'd0;
    for (int k = 0; k < 4; k++) begin
      i_addr = 2'(k);
      tick();
      checks++; if (y !== ey[k]) begin errors++; $display("FAIL direct_y[%0d] got %b want %b", k, y, ey[k]); end
      checks++; if (idx !== 2'(k) || vld !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL direct_flags[%0d] got idx=%0d vld=%b busy=%b want idx=%0d vld=1 busy=0", k, idx, vld, busy, k);
      end
    end
    mode = 2'b11; i_addr = 2'd0;
    tick();
    checks++; if (y !== 4'b1000 || vld !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL direct_hold got y=%b vld=%b busy=%b want y=1000 vld=1 busy=0", y, vld, busy);
    end
  endtask

  task automatic test_scan_up;
    logic [1:0] ei [8] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
    logic       ew [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] ey;
    mode = 2'b01; i_addr = 2'd2; dwell = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      ey = 4'b0001 << ei[k];
      checks++; if (idx !== ei[k] || wrap !== ew[k]) begin
        errors++; $display("FAIL scan_up[%0d] got idx=%0d wrap=%b want idx=%0d wrap=%b", k, idx, wrap, ei[k], ew[k]);
      end
      checks++; if (y !== ey || busy !== 1'b1 || vld !== 1'b1) begin
        errors++; $display("FAIL scan_up_y[%0d] got y=%b busy=%b vld=%b want y=%b busy=1 vld=1", k, y, busy, vld, ey);
      end
    end
  endtask

  task automatic test_hold;
    logic [1:0] ei [3] = '{2'd0, 2'd0, 2'd1};
    mode = 2'b11;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (idx !== 2'd0 || y !== 4'b0001 || wrap !== 1'b0 || busy !== 1'b1 || vld !== 1'b1) begin
        errors++; $display("FAIL hold[%0d] got idx=%0d y=%b wrap=%b busy=%b vld=%b want idx=0 y=0001 wrap=0 busy=1 vld=1",
                           k, idx, y, wrap, busy, vld);
      end
    end
    mode = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (idx !== ei[k] || wrap !== 1'b0) begin
        errors++; $display("FAIL resume[%0d] got idx=%0d wrap=%b want idx=%0d wrap=0", k, idx, wrap, ei[k]);
      end
    end
  endtask

  task automatic test_restart;
    start = 1'b1; i_addr = 2'd3;
    tick();
    start = 1'b0;
    checks++; if (idx !== 2'd3 || y !== 4'b1000) begin
      errors++; $display("FAIL restart got idx=%0d y=%b want idx=3 y=1000", idx, y);
    end
    tick();
    checks++; if (idx !== 2'd3) begin errors++; $display("FAIL restart_dwell got idx=%0d want 3", idx); end
  endtask

  task automatic test_en_off;
    en = 1'b0;
    tick();
    checks++; if (y !== 4'b0000 || vld !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL en_off got y=%b vld=%b busy=%b want y=0000 vld=0 busy=0", y, vld, busy);
    end
  endtask

  task automatic test_start_ignored;
    en = 1'b1; mode = 2'b11; start = 1'b1; i_addr = 2'd1;
    tick();
    checks++; if (y !== 4'b0000 || vld !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL start_hold_ignored got y=%b vld=%b busy=%b want y=0000 vld=0 busy=0", y, vld, busy);
    end
    mode = 2'b00; i_addr = 2'd2;
    tick();
    start = 1'b0;
    checks++; if (y !== 4'b0100 || vld !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL start_direct_ignored got y=%b vld=%b busy=%b want y=0100 vld=1 busy=0", y, vld, busy);
    end
  endtask

  task automatic test_reset_mid_scan;
    mode = 2'b01; dwell = 4'd3; i_addr = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0; start = 1'b1; i_addr = 2'd2;
    tick();
    checks++; if (y !== 4'b0000 || idx !== 2'd0 || {vld, wrap, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_mid_scan got y=%b idx=%0d flags=%b want y=0000 idx=0 flags=000", y, idx, {vld, wrap, busy});
    end
    rst_n = 1'b1; start = 1'b0;
    tick();
    checks++; if (vld !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got vld=%b busy=%b want 0 0", vld, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (idx !== 2'd2 || y !== 4'b0100 || busy !== 1'b1) begin
      errors++; $display("FAIL post_reset_start got idx=%0d y=%b busy=%b want idx=2 y=0100 busy=1", idx, y, busy);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (idx !== ((k < 3) ? 2'd2 : 2'd3)) begin
        errors++; $display("FAIL post_reset_dwell[%0d] got idx=%0d want %0d", k, idx, (k < 3) ? 2 : 3);
      end
    end
  endtask

  task automatic test_scan_dn_n3;
    logic [2:0] ei [7] = '{3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd5, 3'd4};
    logic       ew [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    en3 = 1'b1; mode3 = 2'b10; i3 = 3'd1; dwell3 = 4'd0; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) dwell3 = 4'd1;
      if (k > 0) tick();
      checks++; if (idx3 !== ei[k] || wrap3 !== ew[k]) begin
        errors++; $display("FAIL scan_dn[%0d] got idx=%0d wrap=%b want idx=%0d wrap=%b", k, idx3, wrap3, ei[k], ew[k]);
      end
      if (k == 2) begin
        checks++; if (y3 !== 8'b1000_0000) begin errors++; $display("FAIL scan_dn_wrap_y got %b want 10000000", y3); end
      end
    end
    en3 = 1'b0;
    tick();
    checks++; if (y3 !== 8'b0000_0001 || vld3 !== 1'b0 || busy3 !== 1'b0) begin
      errors++; $display("FAIL en_off_onehot got y=%b vld=%b busy=%b want y=00000001 vld=0 busy=0", y3, vld3, busy3);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; start = 1'b0; mode = 2'b00; i_addr = 2'd0; dwell = 4'd0;
    en3 = 1'b0; start3 = 1'b0; mode3 = 2'b00; i3 = 3'd0; dwell3 = 4'd0;
    test_reset();
    test_direct();
    test_scan_up();
    test_hold();
    test_restart();
    test_en_off();
    test_start_ignored();
    test_scan_dn_n3();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
